register_file: RTL and testbench
================================

# register_file

Architectural register file for the 5-stage integer pipeline: 32 entries × 32 bits, two asynchronous read ports feeding the decode stage, and one synchronous write port driven by the write-back stage. Register 0 reads as zero. A same-cycle write-to-read bypass lets decode observe the value being retired in that cycle. A clear sequencer zeroes the array after reset, or on request, one entry per cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of architectural registers
- ADDR_WIDTH, 6, port address width; bits [4:0] select the entry, bit 5 marks out-of-range

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- register_file_read_address_1  input  6  read port 1 address (rs)
- register_file_read_address_2  input  6  read port 2 address (rt)
- register_file_read_value_1  output  32  read port 1 data, combinational
- register_file_read_value_2  output  32  read port 2 data, combinational
- register_file_write_address  input  6  write address
- register_file_write_value  input  32  write data
- register_file_write_enable  input  1  write strobe, sampled at rising edge
- register_file_reset  input  1  synchronous clear request, active-high, sampled at rising edge
- register_file_ready  output  1  high when the array is valid and accepting writes

## Operation
- FSM states: CLEAR and IDLE.
- Reset asserted (low): the FSM enters CLEAR asynchronously and clear_index goes to 0. Array contents are not reset directly.
- CLEAR behaviour:
  - Each cycle writes 0 to entry clear_index, then increments the index.
  - After writing entry 31, the FSM moves to IDLE on that same edge.
  - The index does not wrap back into CLEAR.
- IDLE to CLEAR: register_file_reset = 1 at an edge moves to CLEAR with clear_index = 0 and discards any write in that cycle.
- In CLEAR:
  - Writes are dropped.
  - Both read outputs are forced to 0.
  - register_file_ready = 0.
- register_file_reset = 1 while already in CLEAR restarts the sweep at index 0.
- Writes in IDLE with enable = 1 update the entry at the rising edge, except in two cases where the write is silently dropped:
  - address[4:0] = 0
  - address[5] = 1
- Read, per port:
  - Returns 0 if address[5] = 1 or address[4:0] = 0.
  - Otherwise, if a write is accepted this cycle to the identical address, returns register_file_write_value (bypass).
  - Otherwise returns the stored entry.
- Both ports may read the same address. Both then return the same value, including the bypass case.

## Timing
- Reads: zero-cycle combinational path from address (and from write port signals for the bypass) to data.
- Writes: one-cycle latency. Data is visible from storage on the cycle after the edge, and via the bypass in the same cycle.
- Clear sweep from reset release:
  - Exactly 32 rising edges of CLEAR.
  - register_file_ready rises after the 32nd edge.
- Clear sweep on request: the edge sampling register_file_reset enters CLEAR. ready falls after that edge and rises 32 edges later.
- Reset values:
  - register_file_ready = 0
  - both read values = 0
  - FSM = CLEAR, clear_index = 0
- Reset asserted mid-sweep or mid-write: the in-flight write is abandoned and the sweep restarts from 0 after release.
- Simultaneous register_file_reset and register_file_write_enable in IDLE: clear wins and the write is dropped.

## Structure
- Shared package register_file_pkg holds:
  - DATA_WIDTH, NUM_REGS, ADDR_WIDTH, REG_INDEX_WIDTH = 5 constants
  - the FSM state type {CLEAR, IDLE}
  - the zero-register index constant
- One sub-module, register_file_clear_sequencer, owns:
  - the FSM and clear_index counter
  - outputs clear_write_enable, clear_address, and ready
- The top level muxes the write port between the sequencer and the pipeline, and holds the storage array and the bypass/read logic.

## Test plan
- Reset release: hold reset low for 3 cycles, then release.
  - ready = 0 for 32 edges, then 1.
  - All 31 readable registers read 0.
- Write then read: in IDLE, write 0xDEADBEEF to r5.
  - Next cycle, read_address_1 = 5 returns 0xDEADBEEF.
  - read_address_2 = 6 returns 0.
- Bypass: write 0x12345678 to r7 while both read ports address r7.
  - Both outputs show 0x12345678 in the same cycle.
  - Storage holds it on the next cycle.
- Zero and out-of-range: write 0xFFFFFFFF to address 0 and to address 0x25.
  - Reads of 0 and 0x25 return 0.
  - r5 is unchanged.
- Clear request: fill r1..r31 with their index values, then pulse register_file_reset for 1 cycle.
  - ready is low for 32 cycles.
  - A write to r3 issued during the sweep is dropped.
  - Afterwards all registers read 0.
- Async reset mid-sweep: assert reset at sweep index 10.
  - After release, ready stays low for a full 32 edges.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants, FSM state encoding and address helpers for the
// architectural register file.
package register_file_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int NUM_REGS        = 32;
    localparam int ADDR_WIDTH      = 6;
    localparam int REG_INDEX_WIDTH = 5;

    typedef logic [0:0] rf_state_t;
    localparam rf_state_t CLEAR = 1'b0;
    localparam rf_state_t IDLE  = 1'b1;

    localparam logic [REG_INDEX_WIDTH-1:0] ZERO_REG = 5'd0;

    // Bit 5 flags out-of-range; entry 0 is hardwired to zero.
    function automatic logic addr_is_live(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[ADDR_WIDTH-1] == 1'b0) && (addr[REG_INDEX_WIDTH-1:0] != ZERO_REG);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/write-back side bus of the register file.
interface register_file_if;
    import register_file_pkg::*;

    logic [ADDR_WIDTH-1:0] register_file_read_address_1;
    logic [ADDR_WIDTH-1:0] register_file_read_address_2;
    logic [DATA_WIDTH-1:0] register_file_read_value_1;
    logic [DATA_WIDTH-1:0] register_file_read_value_2;
    logic [ADDR_WIDTH-1:0] register_file_write_address;
    logic [DATA_WIDTH-1:0] register_file_write_value;
    logic                  register_file_write_enable;
    logic                  register_file_reset;
    logic                  register_file_ready;

    modport master (
        output register_file_read_address_1, register_file_read_address_2,
        output register_file_write_address, register_file_write_value,
        output register_file_write_enable, register_file_reset,
        input  register_file_read_value_1, register_file_read_value_2,
        input  register_file_ready
    );

    modport slave (
        input  register_file_read_address_1, register_file_read_address_2,
        input  register_file_write_address, register_file_write_value,
        input  register_file_write_enable, register_file_reset,
        output register_file_read_value_1, register_file_read_value_2,
        output register_file_ready
    );
endinterface

// File: rtl/register_file_clear_sequencer.sv
// Sweeps zeroes through every entry after reset or on a clear request,
// one entry per cycle, and reports when the array is usable.
module register_file_clear_sequencer
    import register_file_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_clear_request,
    output logic                       o_clear_write_enable,
    output logic [REG_INDEX_WIDTH-1:0] o_clear_address,
    output logic                       o_ready
);

    rf_state_t                  r_state;
    logic [REG_INDEX_WIDTH-1:0] r_clear_index;

    // State and sweep index; a clear request restarts the sweep from any state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= CLEAR;
            r_clear_index <= 5'd0;
        end else if (i_clear_request) begin
            r_state       <= CLEAR;
            r_clear_index <= 5'd0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clear_index <= r_clear_index + 5'd1;
                    if (r_clear_index == 5'd31) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= CLEAR;
                    end
                end
                IDLE: begin
                    r_state       <= IDLE;
                    r_clear_index <= 5'd0;
                end
                default: begin
                    r_state       <= CLEAR;
                    r_clear_index <= 5'd0;
                end
            endcase
        end
    end

    assign o_clear_write_enable = (r_state == CLEAR);
    assign o_clear_address      = r_clear_index;
    assign o_ready              = (r_state == IDLE);

endmodule

// File: rtl/register_file.sv
// 32x32 architectural register file: two combinational read ports with
// same-cycle write bypass, one write port shared with the clear sweep.
module register_file
    import register_file_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    register_file_if.slave  rf_bus
);

    logic [DATA_WIDTH-1:0]      r_regs [NUM_REGS];
    logic                       w_clear_write_enable;
    logic [REG_INDEX_WIDTH-1:0] w_clear_address;
    logic                       w_ready;
    logic                       w_pipe_accept;
    logic                       w_write_enable;
    logic [REG_INDEX_WIDTH-1:0] w_write_index;
    logic [DATA_WIDTH-1:0]      w_write_data;
    logic [DATA_WIDTH-1:0]      w_read_value_1;
    logic [DATA_WIDTH-1:0]      w_read_value_2;

    register_file_clear_sequencer u_clear_sequencer (
        .clock                (clock),
        .reset                (reset),
        .i_clear_request      (rf_bus.register_file_reset),
        .o_clear_write_enable (w_clear_write_enable),
        .o_clear_address      (w_clear_address),
        .o_ready              (w_ready)
    );

    // A clear request in the same cycle wins over a pipeline write.
    assign w_pipe_accept = w_ready
                         & rf_bus.register_file_write_enable
                         & ~rf_bus.register_file_reset
                         & addr_is_live(rf_bus.register_file_write_address);

    // Write port mux: the sweep owns the port whenever it is active.
    always_comb begin
        w_write_enable = 1'b0;
        w_write_index  = ZERO_REG;
        w_write_data   = 32'd0;
        if (w_clear_write_enable) begin
            w_write_enable = 1'b1;
            w_write_index  = w_clear_address;
            w_write_data   = 32'd0;
        end else begin
            w_write_enable = w_pipe_accept;
            w_write_index  = rf_bus.register_file_write_address[REG_INDEX_WIDTH-1:0];
            w_write_data   = rf_bus.register_file_write_value;
        end
    end

    // Storage array; contents are only ever initialised by the sweep.
    always_ff @(posedge clock) begin
        if (w_write_enable) begin
            r_regs[w_write_index] <= w_write_data;
        end
    end

    // Read port 1: zero/out-of-range, then bypass, then storage.
    always_comb begin
        w_read_value_1 = 32'd0;
        if (!w_ready || !addr_is_live(rf_bus.register_file_read_address_1)) begin
            w_read_value_1 = 32'd0;
        end else if (w_pipe_accept &&
                     (rf_bus.register_file_read_address_1 == rf_bus.register_file_write_address)) begin
            w_read_value_1 = rf_bus.register_file_write_value;
        end else begin
            w_read_value_1 = r_regs[rf_bus.register_file_read_address_1[REG_INDEX_WIDTH-1:0]];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        w_read_value_2 = 32'd0;
        if (!w_ready || !addr_is_live(rf_bus.register_file_read_address_2)) begin
            w_read_value_2 = 32'd0;
        end else if (w_pipe_accept &&
                     (rf_bus.register_file_read_address_2 == rf_bus.register_file_write_address)) begin
            w_read_value_2 = rf_bus.register_file_write_value;
        end else begin
            w_read_value_2 = r_regs[rf_bus.register_file_read_address_2[REG_INDEX_WIDTH-1:0]];
        end
    end

    assign rf_bus.register_file_read_value_1 = w_read_value_1;
    assign rf_bus.register_file_read_value_2 = w_read_value_2;
    assign rf_bus.register_file_ready        = w_ready;

endmodule

// File: tb/tb_register_file.sv
// Randomized scoreboard bench for register_file against an array-based model.
module tb_register_file;

    logic clock;
    logic reset;

    register_file_if rf_bus ();

    register_file dut (
        .clock  (clock),
        .reset  (reset),
        .rf_bus (rf_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] v1;
        logic [31:0] v2;
        logic        rdy;
        int          tag;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          tag_cnt  = 0;

    // Reference model: plain array plus count of clear edges still to come.
    logic [31:0] m_mem [32];
    int          m_clear_left = 32;

    function automatic logic m_live(input logic [5:0] a);
        return (a < 6'd32) && (a != 6'd0);
    endfunction

    function automatic logic m_accept();
        return (m_clear_left == 0) && rf_bus.register_file_write_enable &&
               !rf_bus.register_file_reset && reset &&
               m_live(rf_bus.register_file_write_address);
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        if (m_clear_left != 0 || !m_live(a)) return 32'd0;
        if (m_accept() && a == rf_bus.register_file_write_address)
            return rf_bus.register_file_write_value;
        return m_mem[a];
    endfunction

    task automatic m_start_clear();
        m_clear_left = 32;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    endtask

    // Model effect of the rising edge that just happened, using held inputs.
    task automatic m_edge();
        if (!reset) begin
            m_start_clear();
        end else if (rf_bus.register_file_reset) begin
            m_start_clear();
        end else if (m_clear_left > 0) begin
            m_clear_left--;
        end else if (m_accept()) begin
            m_mem[rf_bus.register_file_write_address] = rf_bus.register_file_write_value;
        end
    endtask

    task automatic step(input logic rst_v, input logic clr_v, input logic we_v,
                        input logic [5:0] wa, input logic [31:0] wd,
                        input logic [5:0] a1, input logic [5:0] a2);
        exp_t e;
        @(posedge clock);
        m_edge();
        #1;
        reset                               = rst_v;
        rf_bus.register_file_reset          = clr_v;
        rf_bus.register_file_write_enable   = we_v;
        rf_bus.register_file_write_address  = wa;
        rf_bus.register_file_write_value    = wd;
        rf_bus.register_file_read_address_1 = a1;
        rf_bus.register_file_read_address_2 = a2;
        if (!rst_v) m_start_clear();
        e.v1  = m_read(a1);
        e.v2  = m_read(a2);
        e.rdy = (m_clear_left == 0);
        e.tag = tag_cnt;
        tag_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic idle_read(input logic [5:0] a1, input logic [5:0] a2);
        step(1'b1, 1'b0, 1'b0, 6'd0, 32'd0, a1, a2);
    endtask

    task automatic check32(input string name, input int tag,
                           input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s tag=%0d got=%h want=%h", name, tag, got, want);
        end
    endtask

    // Monitor: compares every presented output cycle against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check32("ready", e.tag, {31'd0, rf_bus.register_file_ready}, {31'd0, e.rdy});
            check32("read1", e.tag, rf_bus.register_file_read_value_1, e.v1);
            check32("read2", e.tag, rf_bus.register_file_read_value_2, e.v2);
        end
    end

    task automatic random_traffic(input int n);
        logic [5:0]  wa;
        logic [5:0]  a1;
        logic [5:0]  a2;
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            wa = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
            a2 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 31));
            step(1'b1, ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, wa, wd, a1, a2);
        end
    endtask

    initial begin
        int budget;
        reset                               = 1'b0;
        rf_bus.register_file_reset          = 1'b0;
        rf_bus.register_file_write_enable   = 1'b0;
        rf_bus.register_file_write_address  = 6'd0;
        rf_bus.register_file_write_value    = 32'd0;
        rf_bus.register_file_read_address_1 = 6'd0;
        rf_bus.register_file_read_address_2 = 6'd0;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;

        // Reset for 3 cycles, then the sweep, then read every register.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd1, 6'd2);
        for (int i = 0; i < 34; i++) idle_read(6'd5, 6'd31);
        for (int i = 1; i < 32; i++) idle_read(6'(i), 6'(32 - i));

        // Write then read, and same-cycle bypass on both ports.
        step(1'b1, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 6'd5, 6'd6);
        idle_read(6'd5, 6'd6);
        step(1'b1, 1'b0, 1'b1, 6'd7, 32'h12345678, 6'd7, 6'd7);
        idle_read(6'd7, 6'd7);

        // Writes to the zero register and out-of-range address are dropped.
        step(1'b1, 1'b0, 1'b1, 6'd0, 32'hFFFFFFFF, 6'd0, 6'h25);
        step(1'b1, 1'b0, 1'b1, 6'h25, 32'hFFFFFFFF, 6'h25, 6'd0);
        idle_read(6'd5, 6'h25);

        // Fill, clear request, dropped write during sweep, then all zero.
        for (int i = 1; i < 32; i++) step(1'b1, 1'b0, 1'b1, 6'(i), 32'(i), 6'(i), 6'd1);
        step(1'b1, 1'b1, 1'b1, 6'd9, 32'hA5A5A5A5, 6'd9, 6'd3);
        for (int i = 0; i < 34; i++)
            step(1'b1, 1'b0, (i == 3), 6'd3, 32'hCAFEF00D, 6'd3, 6'd4);
        for (int i = 1; i < 32; i++) idle_read(6'(i), 6'd3);

        // Async reset mid-sweep restarts the full 32-edge sweep.
        random_traffic(40);
        step(1'b1, 1'b1, 1'b0, 6'd0, 32'd0, 6'd1, 6'd2);
        for (int i = 0; i < 10; i++) idle_read(6'd1, 6'd2);
        step(1'b0, 1'b0, 1'b1, 6'd4, 32'h11111111, 6'd4, 6'd4);
        step(1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 6'd4, 6'd4);
        for (int i = 0; i < 34; i++) idle_read(6'd4, 6'd8);

        random_traffic(400);
        for (int i = 1; i < 32; i++) idle_read(6'(i), 6'(i ^ 1));

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
